// File: rtl/kbd_rx_pkg.sv
// Shared definitions for the keyboard serial receiver.
//   - Default timing and buffer parameters
//   - Frame constants (8N1)
//   - Receiver FSM state encoding
package kbd_rx_pkg;

    // Default clock cycles per serial bit (must be even and >= 4).
    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    // Default receive buffer depth (must be a power of two and >= 2).
    localparam int unsigned DEF_FIFO_DEPTH   = 8;
    // Data bits per frame.
    localparam int unsigned DATA_BITS        = 8;

    typedef logic [DATA_BITS-1:0] kbd_byte_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/kbd_rx_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte buffer.
// Ports:
//   i_clk, i_rst_n  clock / asynchronous active-low reset
//   i_push, i_data  write strobe and byte
//   i_pop           read strobe (ignored when empty)
//   o_data          byte at the head (raw memory read)
//   o_full, o_empty occupancy flags
//   o_count         number of stored entries, log2(DEPTH)+1 bits
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo
    import kbd_rx_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic [7:0]      i_data,
    input  logic            i_pop,
    output logic [7:0]      o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [AW:0]     o_count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rd_ptr];

    // A pop on an empty buffer is a no-op; a push into a full buffer only
    // fits if the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_rx.sv
// kbd_rx: 8N1 serial keyboard receiver with a byte buffer.
// Ports:
//   clock, reset_n   system clock / asynchronous active-low reset
//   rx               asynchronous serial line, idle high, LSB first
//   read             CPU pop strobe (one cycle per byte)
//   data, valid      head of the receive buffer; data is 0 while empty
//   overflow         sticky: a byte was dropped because the buffer was full
//   framing_error    sticky: a stop bit was sampled low
//   clear_errors     synchronous clear of both sticky flags
module kbd_rx
    import kbd_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       framing_error,
    input  logic       clear_errors
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    // Synchronizer and edge detector
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx_s;
    logic w_fall;

    // FSM and datapath
    rx_state_e r_state;
    rx_state_e w_state_next;
    logic [TW-1:0] r_timer;
    logic [BW-1:0] r_bit_cnt;
    kbd_byte_t     r_shift;

    logic w_half_tick;
    logic w_full_tick;
    logic w_timer_clr;
    logic w_shift_en;
    logic w_push;
    logic w_frame_err;

    // Buffer interface
    logic [7:0]    w_fifo_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_drop;

    logic r_overflow;
    logic r_framing_error;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; r_rx_prev holds the previous synchronized
    // value for falling-edge detection. All reset to the idle-line level.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;
    // Edge-triggered start: a line held low after a bad frame never restarts.
    assign w_fall = r_rx_prev & ~w_rx_s;

    assign w_half_tick = (r_timer == HALF_TICK);
    assign w_full_tick = (r_timer == FULL_TICK);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (w_half_tick) begin
                    w_state_next = w_rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (w_full_tick && (r_bit_cnt == LAST_BIT)) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_full_tick) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (datapath controls)
    // ------------------------------------------------------------------
    always_comb begin
        w_timer_clr = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_timer_clr = 1'b1;
            end
            StStart: begin
                // Restart the timer so data samples land on bit centres.
                w_timer_clr = w_half_tick;
            end
            StData: begin
                w_timer_clr = w_full_tick;
                w_shift_en  = w_full_tick;
            end
            StStop: begin
                w_timer_clr = w_full_tick;
                w_push      = w_full_tick & w_rx_s;
                w_frame_err = w_full_tick & ~w_rx_s;
            end
            default: w_timer_clr = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timer, bit counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
        end else if (r_state != StData) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------------
    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (read),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A simultaneous pop makes room, so only an unpaired push into a full
    // buffer is lost.
    assign w_drop = w_push & w_fifo_full & ~read;

    // ------------------------------------------------------------------
    // Sticky error flags; a new error event wins over clear_errors.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_errors) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_err) begin
                r_framing_error <= 1'b1;
            end else if (clear_errors) begin
                r_framing_error <= 1'b0;
            end
        end
    end

    assign valid         = ~w_fifo_empty;
    assign data          = (w_fifo_count != '0) ? w_fifo_head : 8'h00;
    assign overflow      = r_overflow;
    assign framing_error = r_framing_error;

endmodule
